// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the Common Data Bus arbiter: requester count,
// ROB index and result widths, and the fixed source numbering.
package cdb_arbiter_pkg;

  localparam int NREQ   = 3;
  localparam int ROB_W  = 4;
  localparam int DATA_W = 32;

  // Width of a requester index (also the width of cdb_src and rr_ptr).
  localparam int SRC_W  = 2;

  // Fixed requester numbering.
  localparam logic [SRC_W-1:0] SRC_ALU = 2'd0;
  localparam logic [SRC_W-1:0] SRC_LSB = 2'd1;
  localparam logic [SRC_W-1:0] SRC_BR  = 2'd2;

  // Round-robin successor: the requester after idx, wrapping NREQ-1 back to 0.
  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] idx);
    if (idx == SRC_W'(NREQ - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request side and broadcast side of the Common Data Bus.
// master: the execution units / write-back consumers.
// slave:  the arbiter itself.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ROB_W-1:0]  req_rob_id;
  logic [NREQ*DATA_W-1:0] req_val;
  logic [NREQ-1:0]        req_ready;

  logic                   cdb_valid;
  logic [ROB_W-1:0]       cdb_rob_id;
  logic [DATA_W-1:0]      cdb_val;
  logic [SRC_W-1:0]       cdb_src;

  modport master (
    output req_valid,
    output req_rob_id,
    output req_val,
    input  req_ready,
    input  cdb_valid,
    input  cdb_rob_id,
    input  cdb_val,
    input  cdb_src
  );

  modport slave (
    input  req_valid,
    input  req_rob_id,
    input  req_val,
    output req_ready,
    output cdb_valid,
    output cdb_rob_id,
    output cdb_val,
    output cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Rotate-priority encoder: the first set request found scanning from rr_ptr
// upward (modulo NREQ) wins. Purely combinational.
module cdb_arbiter_rr_picker
  import cdb_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  localparam logic [SRC_W:0] NREQ_X = (SRC_W + 1)'(NREQ);

  // Scan the NREQ positions starting at rr_ptr; the first hit is latched by 'any'.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] pos;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    pos = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
      if (sum >= NREQ_X) begin
        sum = sum - NREQ_X;
      end
      pos = sum[SRC_W-1:0];
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter. Picks at most one finished result per cycle with
// round-robin priority and registers it onto the CDB for the ROB and the
// reservation stations. rdy=0 freezes everything; flush drops the pending
// broadcast and restarts the rotation at the ALU.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  logic [SRC_W-1:0]  rr_ptr;
  logic [NREQ-1:0]   pick_gnt;
  logic [SRC_W-1:0]  pick_idx;
  logic              pick_any;
  logic              grant_en;

  logic [ROB_W-1:0]  sel_rob_id;
  logic [DATA_W-1:0] sel_val;

  logic              cdb_valid_q;
  logic [ROB_W-1:0]  cdb_rob_id_q;
  logic [DATA_W-1:0] cdb_val_q;
  logic [SRC_W-1:0]  cdb_src_q;

  // Only requesters with valid high are ever offered to the picker, so a grant
  // can never land on an idle unit.
  cdb_arbiter_rr_picker u_picker (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Grants are suppressed while in reset, frozen, or flushing.
  assign grant_en      = rst & rdy & ~flush;
  assign bus.req_ready = grant_en ? pick_gnt : '0;

  // Route the winning requester's ROB index and value to the output register.
  always_comb begin
    sel_rob_id = '0;
    sel_val    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == SRC_W'(i)) begin
        sel_rob_id = bus.req_rob_id[i*ROB_W +: ROB_W];
        sel_val    = bus.req_val[i*DATA_W +: DATA_W];
      end
    end
  end

  // Broadcast register and rotation pointer. Without a grant only cdb_valid
  // drops; the payload fields keep their last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_val_q    <= '0;
      cdb_src_q    <= '0;
    end else if (rdy) begin
      if (flush) begin
        rr_ptr      <= '0;
        cdb_valid_q <= 1'b0;
      end else if (pick_any) begin
        rr_ptr       <= next_ptr(pick_idx);
        cdb_valid_q  <= 1'b1;
        cdb_rob_id_q <= sel_rob_id;
        cdb_val_q    <= sel_val;
        cdb_src_q    <= pick_idx;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_val    = cdb_val_q;
  assign bus.cdb_src    = cdb_src_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single Common Data Bus between the execution units that finish out of order (ALU, load/store buffer, branch unit). Each cycle it selects at most one completed result with round-robin priority and registers it onto the CDB. The ROB and the reservation stations consume that broadcast to mark an entry ready and to wake up dependants. It sits between the execution units and the ROB/RS write-back ports, and is cleared by the misprediction flush.

Parameters:
NREQ, 3, number of requesters (0=ALU, 1=LSB, 2=BR)
ROB_W, 4, ROB index width (matches `RBID)
DATA_W, 32, result width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  core-enable; 0 freezes the block
flush  in  1  misprediction clear
req_valid  in  NREQ  requester i has a result
req_rob_id  in  NREQ*ROB_W  ROB index per requester, slice i at [i*ROB_W +: ROB_W]
req_val  in  NREQ*DATA_W  result per requester, sliced the same way
req_ready  out  NREQ  one-hot grant; combinational
cdb_valid  out  1  broadcast valid, registered
cdb_rob_id  out  ROB_W  broadcast ROB index
cdb_val  out  DATA_W  broadcast value
cdb_src  out  2  index of the granted requester

Behaviour:
- Reset (rst=0, asynchronous):
  - cdb_valid=0, cdb_rob_id=0, cdb_val=0, cdb_src=0.
  - rr_ptr=0.
  - req_ready=0 while rst=0.
- Grant is combinational:
  - Condition: rdy=1, flush=0, rst=1.
  - Winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready = one-hot(winner), or 0 if there is no valid request.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] at a posedge.
  - A requester holds valid, rob_id and val stable until it receives ready.
  - The arbiter never grants a requester whose valid is low.
- Latency: a result granted in cycle N appears on the CDB in cycle N+1.
  - cdb_valid=1 for exactly one cycle per transfer.
  - It is re-asserted back-to-back if another grant occurs.
- rr_ptr after a grant: winner+1, wrapping NREQ-1 to 0.
  - With no grant, rr_ptr is unchanged.
  - Any continuously-valid requester waits at most NREQ-1 cycles.
- No grant in a cycle (rdy=1, flush=0): cdb_valid<=0 at the next edge; cdb_rob_id, cdb_val and cdb_src hold their previous values.
- rdy=0:
  - All registers hold, including cdb_valid.
  - req_ready=0.
  - flush is ignored.
- flush=1 with rdy=1:
  - req_ready=0 that cycle.
  - Next edge: cdb_valid<=0 and rr_ptr<=0.
  - Results already on the CDB in the flush cycle are still visible that cycle; consumers discard them.
- Simultaneous requests: exactly one is granted; the losers keep valid high and are served in rotation.
- Reset mid-transfer: the registered broadcast is discarded; requesters re-present their results after reset.

Decomposition:
- Shared defines (defines.v):
  - ROB index width (`RBID`).
  - DATA_W.
  - Source indices SRC_ALU=0, SRC_LSB=1, SRC_BR=2.
  - NREQ.
- One sub-module, rr_picker: purely combinational rotate-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, binary index, any.
- Top level: rr_ptr register, output registers, handshake gating.

Test Plan:
1. Reset with rst=0, then release; no requests -> cdb_valid=0, rr_ptr=0, req_ready=000 for 5 cycles.
2. Single request: ALU presents rob_id=3, val=0x0000_00AA at cycle N -> req_ready=001 at N; at N+1 cdb_valid=1, cdb_rob_id=3, cdb_val=0xAA, cdb_src=0; at N+2 cdb_valid=0.
3. All three requesters valid and held (ids 1/2/3) from rr_ptr=0 -> grants 001, 010, 100 on consecutive cycles; CDB shows ids 1, 2, 3 with src 0, 1, 2 back-to-back; rr_ptr wraps to 0.
4. Fairness wrap: rr_ptr=2, ALU and BR valid -> BR granted first, then ALU; a continuously-valid LSB never waits more than 2 cycles.
5. rdy=0 for 3 cycles while ALU is valid and cdb_valid=1 -> req_ready=000, CDB outputs frozen; on rdy=1 the ALU is granted and the CDB updates the following cycle.
6. flush=1 while LSB valid and rr_ptr=1 -> req_ready=000 that cycle; next cycle cdb_valid=0 and rr_ptr=0; an async rst=0 mid-stream clears cdb_valid immediately, without waiting for clk.
